// File: rtl/hdu_pkg.sv
// -----------------------------------------------------------------------------
// hdu_pkg
// Shared definitions for the hazard-control unit:
//   - ex_jumpop encoding (JOP_*)
//   - legal ranges for LOAD_LAT and FLUSH_DEPTH
//   - hdu_mode_e: the per-cycle decision of the control unit, in priority order
//   - clamp_int: forces an out-of-range parameter into its legal range
// -----------------------------------------------------------------------------
package hdu_pkg;

   // ex_jumpop encoding
   localparam logic [1:0] JOP_NONE = 2'd0;
   localparam logic [1:0] JOP_BR   = 2'd1;  // conditional branch, taken
   localparam logic [1:0] JOP_J    = 2'd2;  // direct jump
   localparam logic [1:0] JOP_JR   = 2'd3;  // register jump

   // Legal parameter ranges
   localparam int LOAD_LAT_MIN    = 1;
   localparam int LOAD_LAT_MAX    = 4;
   localparam int FLUSH_DEPTH_MIN = 2;
   localparam int FLUSH_DEPTH_MAX = 4;

   // Decision taken by the unit in the current cycle, highest priority first.
   typedef enum logic [2:0] {
      HDU_RESET      = 3'd0,
      HDU_FREEZE     = 3'd1,
      HDU_XFER       = 3'd2,
      HDU_FLUSH_TAIL = 3'd3,
      HDU_LOAD_USE   = 3'd4,
      HDU_RUN        = 3'd5
   } hdu_mode_e;

   function automatic int clamp_int(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/hdu_load_scoreboard.sv
// -----------------------------------------------------------------------------
// hdu_load_scoreboard
// Tracks loads that have left EX but whose data is not yet forwardable.
// DEPTH entries of {valid, dest}; entry 0 is the youngest. With DEPTH=0 no
// storage is built and both match outputs are constant 0.
//
// Ports:
//   clk        clock
//   rst        synchronous active-low reset, clears every entry
//   shift_en   advance the shift register this edge (held while frozen)
//   dest_valid the instruction leaving EX is a load with a nonzero dest
//   dest       destination register of the instruction leaving EX
//   rs, rt     source registers of the instruction in ID
//   rs_match   rs equals the dest of some valid entry
//   rt_match   rt equals the dest of some valid entry
// -----------------------------------------------------------------------------
module hdu_load_scoreboard #(
   parameter int REG_AW = 5,
   parameter int DEPTH  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              shift_en,
   input  logic              dest_valid,
   input  logic [REG_AW-1:0] dest,
   input  logic [REG_AW-1:0] rs,
   input  logic [REG_AW-1:0] rt,
   output logic              rs_match,
   output logic              rt_match
);

   generate
      if (DEPTH > 0) begin : g_sb
         logic [DEPTH-1:0]  valid_q;
         logic [REG_AW-1:0] dest_q [DEPTH];

         always_ff @(posedge clk) begin
            if (!rst) begin
               valid_q <= '0;
               for (int i = 0; i < DEPTH; i++) begin
                  dest_q[i] <= '0;
               end
            end else if (shift_en) begin
               for (int i = DEPTH - 1; i > 0; i--) begin
                  valid_q[i] <= valid_q[i-1];
                  dest_q[i]  <= dest_q[i-1];
               end
               // A bubble or non-load in EX enters as an invalid entry.
               valid_q[0] <= dest_valid;
               dest_q[0]  <= dest;
            end
         end

         always_comb begin
            rs_match = 1'b0;
            rt_match = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
               if (valid_q[i] && (dest_q[i] == rs)) rs_match = 1'b1;
               if (valid_q[i] && (dest_q[i] == rt)) rt_match = 1'b1;
            end
         end
      end else begin : g_no_sb
         // Single-cycle load latency: the EX-stage compare covers everything.
         logic unused_inputs;
         assign unused_inputs = ^{clk, rst, shift_en, dest_valid, dest, rs, rt};
         assign rs_match = 1'b0;
         assign rt_match = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard-control unit beside the ID/EX stages. Each cycle it picks one action,
// in priority order: reset, data-memory freeze, taken control transfer,
// remaining fetch-side flush, load-use stall, normal run.
//
// Optional feature: define HDU_PERF_CNT_EN to build saturating stall/flush
// performance counters; otherwise stall_cnt/flush_cnt are tied to 0.
//
// Parameters:
//   REG_AW       register-address width
//   LOAD_LAT     cycles after EX before load data is forwardable (1..4)
//   FLUSH_DEPTH  fetch-side stages killed on a taken transfer (2..4)
//   CNT_W        performance-counter width
// Ports:
//   clk, rst                   clock, synchronous active-low reset
//   id_rs, id_rt               sources of the instruction in ID
//   id_rs_used, id_rt_used     source actually read
//   ex_wr                      destination of the instruction in EX
//   ex_memtoreg, ex_regwrite   EX instruction is a load / writes a register
//   ex_jumpop                  control transfer resolved in EX (JOP_*)
//   mem_req, mem_ready         data-memory access in MEM / access complete
//   pc_write, if_id_write      PC / IF/ID update enables
//   if_flush, id_flush         bubble into IF/ID / ID/EX
//   pipe_freeze                hold EX/MEM and MEM/WB
//   stall_cnt, flush_cnt       performance counters
// -----------------------------------------------------------------------------
module hazard_ctrl
   import hdu_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 2,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic [REG_AW-1:0] ex_wr,
   input  logic              ex_memtoreg,
   input  logic              ex_regwrite,
   input  logic [1:0]        ex_jumpop,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_flush,
   output logic              id_flush,
   output logic              pipe_freeze,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam int LL       = clamp_int(LOAD_LAT, LOAD_LAT_MIN, LOAD_LAT_MAX);
   localparam int FD       = clamp_int(FLUSH_DEPTH, FLUSH_DEPTH_MIN, FLUSH_DEPTH_MAX);
   localparam int SB_DEPTH = LL - 1;
   // The transfer cycle itself kills IF/ID and ID/EX; the rest are tail cycles.
   localparam logic [1:0] TAIL_INIT = 2'(FD - 2);

   hdu_mode_e   mode;
   logic [1:0]  flush_rem;
   logic        frozen;
   logic        xfer;
   logic        ex_load;
   logic        sb_rs_match;
   logic        sb_rt_match;
   logic        rs_hazard;
   logic        rt_hazard;

   assign frozen  = mem_req && !mem_ready;
   assign ex_load = ex_memtoreg && ex_regwrite;

   always_comb begin
      xfer = 1'b0;
      case (ex_jumpop)
         JOP_BR, JOP_J, JOP_JR: xfer = 1'b1;
         JOP_NONE:              xfer = 1'b0;
         default:               xfer = 1'b0;
      endcase
   end

   // Loads older than EX; shifting stops while the back end is frozen so a
   // pending load keeps its position until memory completes.
   hdu_load_scoreboard #(
      .REG_AW (REG_AW),
      .DEPTH  (SB_DEPTH)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .shift_en   (!frozen),
      .dest_valid (ex_load && (ex_wr != '0)),
      .dest       (ex_wr),
      .rs         (id_rs),
      .rt         (id_rt),
      .rs_match   (sb_rs_match),
      .rt_match   (sb_rt_match)
   );

   // Register 0 is hard-wired, so it can never carry a dependency.
   assign rs_hazard = id_rs_used && (id_rs != '0) &&
                      ((ex_load && (id_rs == ex_wr)) || sb_rs_match);
   assign rt_hazard = id_rt_used && (id_rt != '0) &&
                      ((ex_load && (id_rt == ex_wr)) || sb_rt_match);

   // Next decision
   always_comb begin
      mode = HDU_RUN;
      if (!rst)                        mode = HDU_RESET;
      else if (frozen)                 mode = HDU_FREEZE;
      else if (xfer)                   mode = HDU_XFER;
      else if (flush_rem != 2'd0)      mode = HDU_FLUSH_TAIL;
      else if (rs_hazard || rt_hazard) mode = HDU_LOAD_USE;
      else                             mode = HDU_RUN;
   end

   // Outputs
   always_comb begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_flush    = 1'b0;
      id_flush    = 1'b0;
      pipe_freeze = 1'b0;
      case (mode)
         HDU_FREEZE: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pipe_freeze = 1'b1;
         end
         HDU_XFER: begin
            if_flush = 1'b1;
            id_flush = 1'b1;
         end
         HDU_FLUSH_TAIL: begin
            if_flush = 1'b1;
         end
         HDU_LOAD_USE: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_flush    = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Remaining fetch-side flush cycles; held while frozen.
   always_ff @(posedge clk) begin
      if (!rst) begin
         flush_rem <= 2'd0;
      end else begin
         case (mode)
            HDU_XFER:       flush_rem <= TAIL_INIT;
            HDU_FLUSH_TAIL: flush_rem <= flush_rem - 2'd1;
            default:        flush_rem <= flush_rem;
         endcase
      end
   end

`ifdef HDU_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q;
   logic [CNT_W-1:0] flush_q;

   // Saturating counters; freeze cycles count as stalls since pc_write=0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_write && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
         if (if_flush && (flush_q != '1))  flush_q <= flush_q + CNT_W'(1);
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Two instances share one stimulus stream:
//   dut_a: LOAD_LAT=1, FLUSH_DEPTH=2
//   dut_b: LOAD_LAT=3, FLUSH_DEPTH=4
// Each step drives inputs after the rising edge, pushes the expected output
// vector {pc_write, if_id_write, if_flush, id_flush, pipe_freeze} for each
// instance, and pops/compares on the falling edge. Counter expectations come
// from a running tally of the expected vectors (zero unless HDU_PERF_CNT_EN).
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int REG_AW = 5;
   localparam int CNT_W  = 16;

   localparam logic [4:0] O_DEF   = 5'b11000;
   localparam logic [4:0] O_STALL = 5'b00010;
   localparam logic [4:0] O_XFER  = 5'b11110;
   localparam logic [4:0] O_TAIL  = 5'b11100;
   localparam logic [4:0] O_FRZ   = 5'b00001;

`ifdef HDU_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [REG_AW-1:0] id_rs = '0, id_rt = '0, ex_wr = '0;
   logic              id_rs_used = 1'b0, id_rt_used = 1'b0;
   logic              ex_memtoreg = 1'b0, ex_regwrite = 1'b0;
   logic [1:0]        ex_jumpop = 2'd0;
   logic              mem_req = 1'b0, mem_ready = 1'b0;

   logic             pc_write_a, if_id_write_a, if_flush_a, id_flush_a, pipe_freeze_a;
   logic             pc_write_b, if_id_write_b, if_flush_b, id_flush_b, pipe_freeze_b;
   logic [CNT_W-1:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;

   hazard_ctrl #(.REG_AW(REG_AW), .LOAD_LAT(1), .FLUSH_DEPTH(2), .CNT_W(CNT_W)) dut_a (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .ex_wr(ex_wr), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
      .ex_jumpop(ex_jumpop), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_flush(if_flush_a),
      .id_flush(id_flush_a), .pipe_freeze(pipe_freeze_a),
      .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
   );

   hazard_ctrl #(.REG_AW(REG_AW), .LOAD_LAT(3), .FLUSH_DEPTH(4), .CNT_W(CNT_W)) dut_b (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .ex_wr(ex_wr), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
      .ex_jumpop(ex_jumpop), .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_flush(if_flush_b),
      .id_flush(id_flush_b), .pipe_freeze(pipe_freeze_b),
      .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [4:0] exp_qa[$];
   logic [4:0] exp_qb[$];
   int unsigned m_stall_a = 0, m_flush_a = 0, m_stall_b = 0, m_flush_b = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input string tag, input logic r,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic rsu, input logic rtu,
                       input logic [4:0] wr, input logic ld, input logic rw,
                       input logic [1:0] jop, input logic mreq, input logic mrdy,
                       input logic [4:0] ea, input logic [4:0] eb);
      logic [4:0] pa, pb;
      @(posedge clk);
      #1;
      rst         = r;
      id_rs       = rs;
      id_rt       = rt;
      id_rs_used  = rsu;
      id_rt_used  = rtu;
      ex_wr       = wr;
      ex_memtoreg = ld;
      ex_regwrite = ld | rw;
      ex_jumpop   = jop;
      mem_req     = mreq;
      mem_ready   = mrdy;
      exp_qa.push_back(ea);
      exp_qb.push_back(eb);
      @(negedge clk);
      pa = exp_qa.pop_front();
      pb = exp_qb.pop_front();
      check_val({tag, "/a_out"},
                32'({pc_write_a, if_id_write_a, if_flush_a, id_flush_a, pipe_freeze_a}), 32'(pa));
      check_val({tag, "/b_out"},
                32'({pc_write_b, if_id_write_b, if_flush_b, id_flush_b, pipe_freeze_b}), 32'(pb));
      check_val({tag, "/a_stall_cnt"}, 32'(stall_cnt_a), PERF ? m_stall_a : 32'd0);
      check_val({tag, "/a_flush_cnt"}, 32'(flush_cnt_a), PERF ? m_flush_a : 32'd0);
      check_val({tag, "/b_stall_cnt"}, 32'(stall_cnt_b), PERF ? m_stall_b : 32'd0);
      check_val({tag, "/b_flush_cnt"}, 32'(flush_cnt_b), PERF ? m_flush_b : 32'd0);
      // Tally this cycle; it becomes visible after the next edge.
      if (!r) begin
         m_stall_a = 0; m_flush_a = 0; m_stall_b = 0; m_flush_b = 0;
      end else begin
         if (!pa[4]) m_stall_a++;
         if (pa[2])  m_flush_a++;
         if (!pb[4]) m_stall_b++;
         if (pb[2])  m_flush_b++;
      end
   endtask

   task automatic nop_step(input string tag, input logic [4:0] ea, input logic [4:0] eb);
      step(tag, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, ea, eb);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal;
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset holds outputs at default despite freeze, transfer and load-use inputs.
      step("rst_hold0", 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, O_DEF, O_DEF);
      step("rst_hold1", 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, O_DEF, O_DEF);
      nop_step("rst_rel", O_DEF, O_DEF);

      // Immediately dependent load: 1 stall (A), 3 stalls (B).
      step("lu_c0", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, O_STALL, O_STALL);
      step("lu_c1", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, O_DEF, O_STALL);
      step("lu_c2", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, O_DEF, O_STALL);
      step("lu_c3", 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, O_DEF, O_DEF);

      // One independent instruction between load and use (rt path): 2 stalls in B.
      step("gap_c0", 1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, O_DEF, O_DEF);
      step("gap_c1", 1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, O_DEF, O_STALL);
      step("gap_c2", 1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, O_DEF, O_STALL);
      step("gap_c3", 1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, O_DEF, O_DEF);

      // Unused sources never stall.
      step("unused0", 1'b1, 5'd8, 5'd8, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, O_DEF, O_DEF);
      step("unused1", 1'b1, 5'd8, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, O_DEF, O_DEF);
      nop_step("unused2", O_DEF, O_DEF);

      // Taken branch: FLUSH_DEPTH=4 gives two if_flush-only tail cycles in B.
      step("fl_c0", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, O_XFER, O_XFER);
      nop_step("fl_c1", O_DEF, O_TAIL);
      nop_step("fl_c2", O_DEF, O_TAIL);
      nop_step("fl_c3", O_DEF, O_DEF);

      // Freeze for 4 cycles in the middle of a load-use stall; B's stall resumes.
      step("fz_lu0", 1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, O_STALL, O_STALL);
      for (int i = 0; i < 4; i++)
         step("fz_hold", 1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, O_FRZ, O_FRZ);
      step("fz_done", 1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, O_DEF, O_STALL);
      step("fz_lu2", 1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, O_DEF, O_STALL);
      step("fz_lu3", 1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, O_DEF, O_DEF);

      // Freeze during the flush tail holds the remaining count.
      step("ft_c0", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, O_XFER, O_XFER);
      nop_step("ft_c1", O_DEF, O_TAIL);
      for (int i = 0; i < 2; i++)
         step("ft_frz", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, O_FRZ, O_FRZ);
      nop_step("ft_c2", O_DEF, O_TAIL);
      nop_step("ft_c3", O_DEF, O_DEF);

      // Transfer held in a frozen EX flushes when memory completes.
      step("hx_frz", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0, O_FRZ, O_FRZ);
      step("hx_go", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd3, 1'b1, 1'b1, O_XFER, O_XFER);
      nop_step("hx_t1", O_DEF, O_TAIL);
      nop_step("hx_t2", O_DEF, O_TAIL);
      nop_step("hx_t3", O_DEF, O_DEF);

      // Jump with concurrent load-use on $3: flush only; tail also beats load-use.
      step("pri_j", 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, O_XFER, O_XFER);
      step("pri_t1", 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, O_DEF, O_TAIL);
      step("pri_t2", 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, O_DEF, O_TAIL);
      step("pri_t3", 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, O_DEF, O_DEF);

      // Load to $0 never stalls.
      step("zero0", 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, O_DEF, O_DEF);
      step("zero1", 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, O_DEF, O_DEF);

      // Random independent traffic (sources 10..20, destinations 21..31) with
      // random memory waits: only freeze or default is legal.
      for (int i = 0; i < 12; i++) begin
         logic mq, mr;
         logic [4:0] e;
         mq = 1'($urandom_range(0, 1));
         mr = 1'($urandom_range(0, 1));
         e  = (mq && !mr) ? O_FRZ : O_DEF;
         step("rand", 1'b1, 5'($urandom_range(10, 20)), 5'($urandom_range(10, 20)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(21, 31)), 1'($urandom_range(0, 1)), 1'b1,
              2'd0, mq, mr, e, e);
      end
      nop_step("drain0", O_DEF, O_DEF);
      nop_step("drain1", O_DEF, O_DEF);

      // Reset while B has flush_rem=2 and a load to $4 in EX; afterwards
      // nothing is pending and counters read 0.
      step("rf_j", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, O_XFER, O_XFER);
      step("rf_rst", 1'b0, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, O_DEF, O_DEF);
      step("rf_after", 1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, O_DEF, O_DEF);
      check_val("rf_b_stall_zero", 32'(stall_cnt_b), 32'd0);
      check_val("rf_b_flush_zero", 32'(flush_cnt_b), 32'd0);
      nop_step("rf_next", O_DEF, O_DEF);

      check_val("queues_empty", 32'(exp_qa.size() + exp_qb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
